ahb_to_spram: RTL and testbench
===============================

Name: ahb_to_spram

Overview:
- AHB-Lite slave bridge that sits directly upstream of the single-port block RAM wrapper. It converts M0 bus transfers into the RAM's en/addr/byte-we/din port.
- Always zero wait state. Writes are posted; a write that collides with a read is held in a one-entry write buffer.
- Read data is merged with buffered write data, so a read that immediately follows a write returns the written bytes.

Parameters:
- ADDR_WIDTH, 6, RAM word-address width; the RAM holds 2**ADDR_WIDTH words of 32 bits.
- DATA_WIDTH and BYTE_WIDTH are fixed at 32 and 8 and are not parameters.

Ports:
- clka  in  1  clock
- rsta_n  in  1  reset, synchronous, active-low
- hsel  in  1  slave select
- haddr  in  32  byte address; bits [ADDR_WIDTH+1:2] are used
- htrans  in  2  transfer type; only bit 1 (NONSEQ/SEQ) is significant
- hsize  in  3  transfer size
- hwrite  in  1  1 = write
- hwdata  in  32  write data (data phase)
- hready  in  1  bus ready
- hreadyout  out  1  slave ready, tied 1
- hresp  out  1  response, tied 0 (OKAY)
- hrdata  out  32  read data
- ram_en  out  1  RAM enable
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_we  out  4  RAM byte write enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after a read enable (synchronous read, latency 1)

Behaviour:
- Reset (rsta_n low at a rising edge):
  - clears rd_dphase, wr_dphase and buf_valid; any buffered write is discarded.
  - While rsta_n is low: ram_en=0, ram_we=0, hrdata=0.
- Address phase accepted when hsel & hready & htrans[1].
- Byte lanes from hsize and haddr[1:0]:
  - byte: one lane, selected by haddr[1:0].
  - half: lanes 4'b0011 or 4'b1100, selected by haddr[1].
  - word or larger: 4'b1111.
  - Alignment is not checked.
- Accepted read:
  - Same cycle, combinationally: ram_en=1, ram_we=0, ram_addr=haddr[ADDR_WIDTH+1:2].
  - Register rd_dphase=1 and rd_addr.
- Accepted write: register wr_dphase=1, wr_addr and wr_lanes. No RAM access in the address phase.
- Write data phase (wr_dphase=1):
  - No read issued this cycle: write directly. ram_en=1, ram_we=wr_lanes, ram_addr=wr_addr, ram_wdata=hwdata.
  - Read issued this cycle: stash buf_addr=wr_addr, buf_we=wr_lanes, buf_data=hwdata, buf_valid=1.
- Buffer drain:
  - Any cycle with buf_valid=1, no read issued and no write data phase: ram_en=1, ram_we=buf_we, ram_addr=buf_addr, ram_wdata=buf_data; buf_valid=0 at the next edge.
  - A write data phase cannot coincide with a held buffer, because the write's own address phase is a free cycle. One entry is therefore sufficient; the implementation asserts this.
- Read data phase (rd_dphase=1): for each byte i, hrdata[i] = buf_data[i] if buf_valid & buf_we[i] & buf_addr==rd_addr, else ram_rdata[i].
- hrdata=0 when rd_dphase=0.
- When buf_valid drains in the same cycle as a read data phase, the merge uses the pre-clear buffer contents (combinational this cycle).
- hready low with hsel high, htrans IDLE/BUSY, or hsel low: no new address phase; dphase flags clear at the next edge.
- Priority when multiple RAM requests coincide: read address phase > write data phase > buffer drain.

Test Plan:
- Word write 0xDEADBEEF to 0x20, then IDLE, then read 0x20 -> write data phase shows ram_en=1, ram_we=4'hF, ram_addr=8; read returns hrdata=0xDEADBEEF; hreadyout=1 and hresp=0 throughout.
- Back-to-back write 0x10=0xCAFEF00D then read 0x10 -> write stashed (buf_valid=1, ram_we=0 in that cycle); read data phase hrdata=0xCAFEF00D from the merge; drain ram_we=4'hF, ram_addr=4 in the same cycle.
- Preload 0x11223344 at 0x10; byte write 0xAB to 0x13; read 0x10 -> ram_we=4'b1000; hrdata=0xAB223344. Repeat with a half write 0x5566 to 0x10 -> 0xAB225566.
- Write 0x40=0x1 followed by reads 0x44, 0x48, 0x40, then IDLE -> buffer held through the reads; 0x44 and 0x48 return RAM contents unmerged; 0x40 returns 0x1 merged; drain occurs on the first IDLE.
- Reset pulse while buf_valid=1 -> buf_valid=0; ram_en=0 and hrdata=0 during reset; a later read of that address returns the old RAM contents.
- htrans=BUSY, or hsel=0 with htrans=NONSEQ, or hready=0 -> ram_en stays 0 and no data-phase flag is set.

Source files
------------

// File: rtl/ahb_to_spram.sv
// AHB-Lite slave bridge onto a single-port 32-bit block RAM (synchronous read, latency 1).
// Latency: zero wait state; read data appears in the data phase; writes are posted (direct or via a 1-entry buffer).
// Backpressure: none; hreadyout is tied high, and a write colliding with a read is parked in the buffer.
//
// Ports:
//   clka, rsta_n                 clock, synchronous active-low reset
//   hsel/haddr/htrans/hsize/     AHB-Lite address phase
//   hwrite/hready
//   hwdata                       AHB-Lite write data (data phase)
//   hreadyout/hresp/hrdata       AHB-Lite slave response
//   ram_en/ram_addr/ram_we/      RAM request port (byte write enables)
//   ram_wdata
//   ram_rdata                    RAM read data, valid the cycle after a read enable
module ahb_to_spram #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  logic                  accept;
  logic                  rd_issue;
  logic                  wr_accept;
  logic                  stash;
  logic                  drain;
  logic [3:0]            lanes;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  rd_dphase;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_dphase;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_lanes;

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [3:0]            buf_we;
  logic [31:0]           buf_data;

  // Only the word-address bits and transfer-type bit 1 carry meaning here.
  logic unused_ok;
  assign unused_ok = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;

  assign word_addr = haddr[ADDR_WIDTH+1:2];
  assign accept    = hsel & hready & htrans[1];
  assign rd_issue  = accept & ~hwrite;
  assign wr_accept = accept & hwrite;

  // A write data phase that loses the RAM port to a read goes to the buffer;
  // the buffer drains on the next cycle where the port is otherwise unused.
  assign stash = wr_dphase & rd_issue;
  assign drain = buf_valid & ~rd_issue & ~wr_dphase;

  always_comb begin
    lanes = 4'b1111;
    case (hsize)
      3'd0:    lanes = 4'b0001 << haddr[1:0];
      3'd1:    lanes = haddr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      rd_dphase <= 1'b0;
      wr_dphase <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      rd_dphase <= rd_issue;
      wr_dphase <= wr_accept;
      if (stash) begin
        buf_valid <= 1'b1;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rd_issue) begin
      rd_addr <= word_addr;
    end
    if (wr_accept) begin
      wr_addr  <= word_addr;
      wr_lanes <= lanes;
    end
    if (stash) begin
      buf_addr <= wr_addr;
      buf_we   <= wr_lanes;
      buf_data <= hwdata;
    end
  end

  // RAM port arbitration: read address phase, then write data phase, then drain.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rsta_n) begin
      if (rd_issue) begin
        ram_en   = 1'b1;
        ram_addr = word_addr;
      end else if (wr_dphase) begin
        ram_en    = 1'b1;
        ram_we    = wr_lanes;
        ram_addr  = wr_addr;
        ram_wdata = hwdata;
      end else if (buf_valid) begin
        ram_en    = 1'b1;
        ram_we    = buf_we;
        ram_addr  = buf_addr;
        ram_wdata = buf_data;
      end
    end
  end

  // Bytes still parked in the buffer are newer than the RAM copy. The merge
  // uses the buffer as it stands this cycle, even if it drains at this edge.
  always_comb begin
    hrdata = '0;
    if (rsta_n && rd_dphase) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_valid && buf_we[i] && (buf_addr == rd_addr)) begin
          hrdata[8*i +: 8] = buf_data[8*i +: 8];
        end else begin
          hrdata[8*i +: 8] = ram_rdata[8*i +: 8];
        end
      end
    end
  end

  // The write's own address phase always leaves the port free, so the buffer
  // is empty whenever a second stash could be needed.
  a_one_entry: assert property (@(posedge clka) disable iff (!rsta_n) stash |-> !buf_valid);

endmodule

// File: tb/tb_ahb_to_spram.sv
module tb_ahb_to_spram;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rsta_n = 1'b0;
  logic          hsel = 1'b0;
  logic [31:0]   haddr = '0;
  logic [1:0]    htrans = 2'b00;
  logic [2:0]    hsize = 3'd2;
  logic          hwrite = 1'b0;
  logic [31:0]   hwdata = '0;
  logic          hready = 1'b1;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  ahb_to_spram #(.ADDR_WIDTH(AW)) dut (
    .clka(clk), .rsta_n(rsta_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM behind the bridge.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model: memory as the bus master sees it after every transfer.
  logic [31:0] ref_mem [64];

  typedef struct {
    int          cyc;
    logic        en;
    logic [3:0]  we;
    logic [5:0]  addr;
    logic [31:0] wd;
  } ram_exp_t;

  logic [31:0] exp_q [$];
  ram_exp_t    ram_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        tb_rd_dph = 1'b0;

  logic        rst_req = 1'b0;
  logic        pend_w = 1'b0;
  logic        pend_r = 1'b0;
  logic [5:0]  pend_idx = '0;
  logic [31:0] pend_data = '0;
  logic [3:0]  pend_lanes = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tb_rd_dph <= rsta_n && hsel && hready && htrans[1] && !hwrite;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [1:0] off);
    if (size == 3'd0) return 4'b0001 << off;
    if (size == 3'd1) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    chk("hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("hresp", {31'd0, hresp}, 32'd0);
    if (!rsta_n) chk("ram_en_in_reset", {31'd0, ram_en}, 32'd0);
    if (tb_rd_dph) begin
      if (exp_q.size() == 0) begin
        chk("rd_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("hrdata", hrdata, rsta_n ? e : 32'd0);
      end
    end else begin
      chk("hrdata_idle", hrdata, 32'd0);
    end
    for (int i = ram_q.size() - 1; i >= 0; i--) begin
      if (ram_q[i].cyc == cyc) begin
        chk("ram_en", {31'd0, ram_en}, {31'd0, ram_q[i].en});
        if (ram_q[i].en) begin
          chk("ram_we", {28'd0, ram_we}, {28'd0, ram_q[i].we});
          chk("ram_addr", {26'd0, ram_addr}, {26'd0, ram_q[i].addr});
          if (ram_q[i].we != 4'd0) chk("ram_wdata", ram_wdata, ram_q[i].wd);
        end
        ram_q.delete(i);
      end else if (ram_q[i].cyc < cyc) begin
        chk("ram_exp_missed", 32'd0, 32'd1);
        ram_q.delete(i);
      end
    end
  end

  task automatic expect_ram(input int c, input logic en, input logic [3:0] we,
                            input logic [5:0] addr, input logic [31:0] wd);
    ram_exp_t x;
    x.cyc = c; x.en = en; x.we = we; x.addr = addr; x.wd = wd;
    ram_q.push_back(x);
  endtask

  // One bus cycle: data phase of the previous write plus a new address phase.
  task automatic step(input logic sel, input logic rdy, input logic [1:0] trans,
                      input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd);
    logic acc;
    @(posedge clk);
    #1;
    rsta_n = rst_req;
    if (pend_w) begin
      hwdata = pend_data;
      if (rst_req)
        for (int i = 0; i < 4; i++)
          if (pend_lanes[i]) ref_mem[pend_idx][8*i +: 8] = pend_data[8*i +: 8];
    end else begin
      hwdata = $urandom;
    end
    hsel = sel; hready = rdy; htrans = trans; hwrite = wr; haddr = addr; hsize = size;
    acc        = rst_req && sel && rdy && trans[1];
    pend_w     = acc && wr;
    pend_r     = acc && !wr;
    pend_idx   = addr[7:2];
    pend_data  = wd;
    pend_lanes = lanes_of(size, addr[1:0]);
    if (acc && !wr) exp_q.push_back(ref_mem[addr[7:2]]);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 2'b00, 1'b0, $urandom, 3'd2, 32'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    step(1'b1, 1'b1, 2'b10, 1'b1, a, s, d);
  endtask
  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b1, 2'b10, 1'b0, a, 3'd2, 32'd0);
  endtask

  initial begin
    int c;
    logic [31:0] old, v, a, wd;
    logic [1:0]  t;
    logic [2:0]  sz;
    logic        s, r, w;

    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset
    rst_req = 1'b0;
    repeat (3) idle();
    rst_req = 1'b1;
    idle(); c = cyc; expect_ram(c, 1'b0, 4'h0, 6'd0, 32'd0);
    idle();

    // Word write, IDLE, read back
    wr(32'h20, 3'd2, 32'hDEADBEEF); c = cyc;
    expect_ram(c, 1'b0, 4'h0, 6'd0, 32'd0);
    expect_ram(c + 1, 1'b1, 4'hF, 6'd8, 32'hDEADBEEF);
    idle();
    rd(32'h20); c = cyc; expect_ram(c, 1'b1, 4'h0, 6'd8, 32'd0);
    idle(); idle();

    // Write immediately followed by read of the same word: stash, merge, drain
    wr(32'h10, 3'd2, 32'hCAFEF00D);
    rd(32'h10); c = cyc;
    expect_ram(c, 1'b1, 4'h0, 6'd4, 32'd0);
    expect_ram(c + 1, 1'b1, 4'hF, 6'd4, 32'hCAFEF00D);
    idle(); idle();

    // Byte and half-word writes into a preloaded word
    wr(32'h10, 3'd2, 32'h11223344); idle();
    wr(32'h13, 3'd0, 32'hAB000000); c = cyc;
    expect_ram(c + 1, 1'b1, 4'b1000, 6'd4, 32'hAB000000);
    idle(); rd(32'h10); idle();
    wr(32'h10, 3'd1, 32'h00005566); c = cyc;
    expect_ram(c + 1, 1'b1, 4'b0011, 6'd4, 32'h00005566);
    idle(); rd(32'h10); idle(); idle();

    // Buffer held across several reads, merged only on the matching address
    wr(32'h40, 3'd2, 32'h00000001); c = cyc;
    expect_ram(c + 1, 1'b1, 4'h0, 6'h11, 32'd0);
    expect_ram(c + 2, 1'b1, 4'h0, 6'h12, 32'd0);
    expect_ram(c + 3, 1'b1, 4'h0, 6'h10, 32'd0);
    expect_ram(c + 4, 1'b1, 4'hF, 6'h10, 32'h00000001);
    rd(32'h44); rd(32'h48); rd(32'h40); idle(); idle();

    // Reset while a write sits in the buffer: the write is lost
    old = ref_mem[16];
    wr(32'h40, 3'd2, 32'h55AA55AA);
    rd(32'h44);
    ref_mem[16] = old;
    rst_req = 1'b0;
    idle(); c = cyc; expect_ram(c, 1'b0, 4'h0, 6'd0, 32'd0);
    rst_req = 1'b1;
    idle(); c = cyc; expect_ram(c, 1'b0, 4'h0, 6'd0, 32'd0);
    rd(32'h40); idle(); idle();

    // Non-accepted address phases
    step(1'b1, 1'b1, 2'b01, 1'b0, 32'h20, 3'd2, 32'd0); c = cyc;
    expect_ram(c, 1'b0, 4'h0, 6'd0, 32'd0);
    expect_ram(c + 1, 1'b0, 4'h0, 6'd0, 32'd0);
    idle();
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'h12345678); c = cyc;
    expect_ram(c, 1'b0, 4'h0, 6'd0, 32'd0);
    expect_ram(c + 1, 1'b0, 4'h0, 6'd0, 32'd0);
    idle();
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 3'd2, 32'd0); c = cyc;
    expect_ram(c, 1'b0, 4'h0, 6'd0, 32'd0);
    expect_ram(c + 1, 1'b0, 4'h0, 6'd0, 32'd0);
    idle();
    rd(32'h20); idle();

    // Randomized traffic, concentrated on a few words to provoke merges
    for (int n = 0; n < 2000; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[7:2] = 6'($urandom_range(0, 3));
      s  = ($urandom_range(0, 7) != 0);
      t  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      r  = (pend_w || pend_r) ? 1'b1 : ($urandom_range(0, 7) != 0);
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      wd = $urandom;
      step(s, r, t, w, a, sz, wd);
    end
    repeat (4) idle();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("ram_q_empty", ram_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
